// File: rtl/map_scan_pkg.sv
// map_scan_pkg: shared state encoding and default parameters for the
// LED-matrix map scanner (map_scan_ctrl and scan_tick_gen).
package map_scan_pkg;

  localparam int DEF_COLS         = 5;
  localparam int DEF_ROWS         = 7;
  localparam int DEF_SEL_W        = 3;
  localparam int DEF_TICKS        = 4;
  localparam int DEF_BLINK_FRAMES = 2;

  // state    | meaning
  // ST_IDLE  | outputs blanked, waiting for en
  // ST_LATCH | one cycle: frame buffer captures map_in
  // ST_SCAN  | columns driven in turn, TICKS cycles each
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_SCAN  = 2'd2
  } state_e;

endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: per-column dwell divider. tick_last_o pulses on every
// TICKS-th enabled cycle; dropping en_i restarts the count from zero.
module scan_tick_gen
  import map_scan_pkg::*;
#(
  parameter int TICKS = DEF_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic tick_last_o
);

  localparam int TW = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [TW-1:0] LAST = TW'(TICKS - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  // next count: hold at zero while disabled, wrap after the last tick
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || (cnt_q == LAST)) cnt_d = '0;
    else                          cnt_d = cnt_q + 1'b1;
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick_last_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/map_scan_ctrl.sv
// map_scan_ctrl: latches a map pattern once per frame and scans it column
// by column onto an active-low column / active-high row matrix.
// Optional blink gating is compiled in with the macro MAP_SCAN_BLINK_EN.
module map_scan_ctrl
  import map_scan_pkg::*;
#(
  parameter int COLS         = DEF_COLS,
  parameter int ROWS         = DEF_ROWS,
  parameter int SEL_W        = DEF_SEL_W,
  parameter int TICKS        = DEF_TICKS,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 load,
  input  logic [SEL_W-1:0]     sel,
  input  logic [ROWS*COLS-1:0] map_in,
  input  logic                 blink,
  output logic [SEL_W-1:0]     sel_q,
  output logic [COLS-1:0]      col_n,
  output logic [ROWS-1:0]      row,
  output logic                 frame_done,
  output logic                 busy
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

  state_e               state_q, state_d;
  logic                 armed_q;
  logic [CW-1:0]        col_q, col_d;
  logic [SEL_W-1:0]     sel_d;
  logic [SEL_W-1:0]     pend_q, pend_d;
  logic                 pend_vld_q, pend_vld_d;
  logic [ROWS*COLS-1:0] fb_q, fb_d;

  logic                 in_scan;
  logic                 tick_last;
  logic                 frame_end;
  logic                 vis;
  logic [COLS-1:0]      col_oh;
  logic [ROWS-1:0]      row_raw;

  assign in_scan   = (state_q == ST_SCAN);
  assign frame_end = in_scan && tick_last && (col_q == LAST_COL);

  scan_tick_gen #(.TICKS(TICKS)) u_tick (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (in_scan),
    .tick_last_o (tick_last)
  );

  // next-state logic; armed_q holds off the first LATCH for one edge after reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (en && armed_q) state_d = ST_LATCH;
      ST_LATCH: state_d = ST_SCAN;
      ST_SCAN:  if (frame_end) state_d = en ? ST_LATCH : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // column stepping, frame capture and map-select bookkeeping
  always_comb begin
    col_d      = col_q;
    fb_d       = fb_q;
    sel_d      = sel_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;

    if (!in_scan)       col_d = '0;
    else if (tick_last) col_d = (col_q == LAST_COL) ? '0 : col_q + 1'b1;

    if (state_q == ST_LATCH) fb_d = map_in;

    if (state_q == ST_IDLE) begin
      if (load) begin
        sel_d      = sel;
        pend_vld_d = 1'b0;
      end
    end else if (frame_end) begin
      // a load coinciding with frame end beats any older pending request
      if (load)            sel_d = sel;
      else if (pend_vld_q) sel_d = pend_q;
      pend_vld_d = 1'b0;
    end else if (load) begin
      pend_d     = sel;
      pend_vld_d = 1'b1;
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      armed_q    <= 1'b0;
      col_q      <= '0;
      fb_q       <= '0;
      sel_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      armed_q    <= 1'b1;
      col_q      <= col_d;
      fb_q       <= fb_d;
      sel_q      <= sel_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
    end
  end

`ifdef MAP_SCAN_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          vis_q, vis_d;

  // count completed frames while blinking; flip visibility every BLINK_FRAMES
  always_comb begin
    bcnt_d = bcnt_q;
    vis_d  = vis_q;
    if (!blink) begin
      bcnt_d = '0;
      vis_d  = 1'b1;
    end else if (frame_end) begin
      if (bcnt_q == BLINK_LAST) begin
        bcnt_d = '0;
        vis_d  = ~vis_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  // blink registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q <= '0;
      vis_q  <= 1'b1;
    end else begin
      bcnt_q <= bcnt_d;
      vis_q  <= vis_d;
    end
  end

  assign vis = vis_q;
`else
  logic unused_blink;
  assign unused_blink = blink;
  assign vis          = 1'b1;
`endif

  // column one-hot and row slice of the active column
  always_comb begin
    col_oh  = '0;
    row_raw = '0;
    for (int c = 0; c < COLS; c++) begin
      if (col_q == CW'(c)) begin
        col_oh[c] = 1'b1;
        row_raw   = fb_q[c*ROWS +: ROWS];
      end
    end
  end

  assign col_n      = in_scan ? ~col_oh : '1;
  assign row        = (in_scan && vis) ? row_raw : '0;
  assign frame_done = frame_end;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_map_scan_ctrl.sv
// tb_map_scan_ctrl: table vectors, directed corner sequences and a random
// run against a frame-position reference model of the map scanner.
module tb_map_scan_ctrl;

  localparam int COLS  = 5;
  localparam int ROWS  = 7;
  localparam int SEL_W = 3;
  localparam int TICKS = 4;
  localparam int BF    = 2;
  localparam int NB    = COLS * ROWS;
  localparam int LASTP = COLS * TICKS;

  logic             clk, rst_n, en, load, blink;
  logic [SEL_W-1:0] sel, sel_q;
  logic [NB-1:0]    map_in, map_drv;
  logic             dec_mode;
  logic [COLS-1:0]  col_n;
  logic [ROWS-1:0]  row;
  logic             frame_done, busy;

  int checks = 0;
  int errors = 0;

  map_scan_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .SEL_W(SEL_W), .TICKS(TICKS), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .sel(sel),
    .map_in(map_in), .blink(blink), .sel_q(sel_q), .col_n(col_n),
    .row(row), .frame_done(frame_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // external map decoder: each column of map s shows s*9+1
  function automatic logic [NB-1:0] dec(input logic [SEL_W-1:0] s);
    logic [6:0] r;
    r = 7'(s) * 7'd9 + 7'd1;
    return {5{r}};
  endfunction

  always_comb map_in = dec_mode ? dec(sel_q) : map_drv;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_col(input logic [COLS-1:0] tgt, input string name);
    int n = 0;
    while (col_n !== tgt && n < 60) begin step(); n++; end
    chk(name, col_n, tgt);
  endtask

  task automatic wait_fd(input string name);
    int n = 0;
    while (frame_done !== 1'b1 && n < 60) begin step(); n++; end
    chk(name, frame_done, 1);
  endtask

  // reference model: frame position (-1 idle, 0 latch, 1..LASTP scan)
  int               m_phase, m_bcnt;
  bit               m_pv, m_armed;
  logic [SEL_W-1:0] m_sel, m_pend;
  logic [NB-1:0]    m_fb;

  task automatic model_reset();
    m_phase = -1; m_bcnt = 0; m_pv = 0; m_armed = 0;
    m_sel = '0; m_pend = '0; m_fb = '0;
  endtask

  task automatic model_step(input logic e, input logic l, input logic [SEL_W-1:0] s,
                            input logic [NB-1:0] mi, input logic b);
    bit last = (m_phase == LASTP);
    if (m_phase < 0) begin
      if (l) begin m_sel = s; m_pv = 0; end
    end else if (last) begin
      if (l) m_sel = s;
      else if (m_pv) m_sel = m_pend;
      m_pv = 0;
    end else if (l) begin
      m_pend = s; m_pv = 1;
    end
    if (m_phase == 0) m_fb = mi;
    if (!b) m_bcnt = 0;
    else if (last) m_bcnt++;
    if (m_phase < 0)  m_phase = (e && m_armed) ? 0 : -1;
    else if (last)    m_phase = e ? 0 : -1;
    else              m_phase++;
    m_armed = 1;
  endtask

  task automatic model_check();
    logic [COLS-1:0] ecol;
    logic [ROWS-1:0] erow;
    bit vis;
    int c;
`ifdef MAP_SCAN_BLINK_EN
    vis = ((m_bcnt / BF) % 2) == 0;
`else
    vis = 1;
`endif
    ecol = '1;
    erow = '0;
    if (m_phase >= 1) begin
      c = (m_phase - 1) / TICKS;
      ecol = ~(COLS'(1) << c);
      if (vis) erow = m_fb[c*ROWS +: ROWS];
    end
    chk("m_col_n", col_n, ecol);
    chk("m_row", row, erow);
    chk("m_fd", frame_done, m_phase == LASTP);
    chk("m_busy", busy, m_phase >= 0);
    chk("m_sel_q", sel_q, m_sel);
  endtask

  typedef struct {
    logic             en;
    logic             load;
    logic [SEL_W-1:0] sel;
    logic [COLS-1:0]  col_n;
    logic [ROWS-1:0]  row;
    logic             fd;
    logic             busy;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int idx, fdcnt;
    bit seen, relatch, vis;

    tbl[0] = '{1'b1, 1'b0, 3'd0, 5'b11111, 7'h00, 1'b0, 1'b1};
    for (int i = 1; i <= 4; i++) tbl[i] = '{1'b1, 1'b0, 3'd0, 5'b11110, 7'h09, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 3'd0, 5'b11101, 7'h4F, 1'b0, 1'b1};

    rst_n = 0; en = 0; load = 0; sel = '0; blink = 0;
    dec_mode = 0; map_drv = 35'h1_2345_6789;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_col_n", col_n, 5'b11111);
    chk("rst_row", row, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sel_q", sel_q, 0);
    chk("rst_fd", frame_done, 0);
    @(negedge clk) rst_n = 1;
    step(); step();
    chk("idle_busy", busy, 0);

    // basic scan vectors
    for (int i = 0; i < 6; i++) begin
      en = tbl[i].en; load = tbl[i].load; sel = tbl[i].sel;
      step();
      chk($sformatf("vec%0d_col_n", i), col_n, tbl[i].col_n);
      chk($sformatf("vec%0d_row", i), row, tbl[i].row);
      chk($sformatf("vec%0d_fd", i), frame_done, tbl[i].fd);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
    end
    idx = 5;
    while (frame_done !== 1'b1 && idx < 40) begin step(); idx++; end
    chk("fd_latency", idx, LASTP);
    step();
    chk("fd_one_cycle", frame_done, 0);
    chk("relatch_col_n", col_n, 5'b11111);
    chk("relatch_busy", busy, 1);
    step();
    map_drv = '1;
    step();
    chk("glitch_row", row, 7'h09);

    // load mid-frame
    dec_mode = 1;
    wait_col(5'b11011, "wait_col2");
    load = 1; sel = 3'd3;
    step();
    load = 0;
    chk("mid_load_sel_q", sel_q, 0);
    wait_fd("wait_fd1");
    chk("fd_sel_q_old", sel_q, 0);
    step();
    chk("fd_sel_q_new", sel_q, 3);
    step();
    chk("new_map_row", row, 7'h1C);

    // load on frame_done cycle overrides an earlier pending load
    load = 1; sel = 3'd2;
    step();
    load = 0;
    wait_fd("wait_fd2");
    load = 1; sel = 3'd5;
    step();
    load = 0;
    chk("load_on_fd", sel_q, 5);
    step();
    chk("load_on_fd_row", row, 7'h2E);
    wait_fd("wait_fd3");
    step();
    chk("pend_discarded", sel_q, 5);

    // en drop mid-frame
    wait_col(5'b11101, "wait_col1");
    en = 0;
    fdcnt = 0; seen = 0; relatch = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (frame_done) begin fdcnt++; seen = 1; end
      else if (seen && busy) relatch = 1;
    end
    chk("en_drop_fd_count", fdcnt, 1);
    chk("en_drop_relatch", relatch, 0);
    chk("en_drop_col_n", col_n, 5'b11111);
    chk("en_drop_busy", busy, 0);

    // reset mid-scan, then first-latch delay
    en = 1;
    wait_col(5'b10111, "wait_col3");
    rst_n = 0;
    #1;
    chk("midrst_col_n", col_n, 5'b11111);
    chk("midrst_row", row, 0);
    chk("midrst_sel_q", sel_q, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_fd", frame_done, 0);
    @(negedge clk) rst_n = 1;
    step();
    chk("arm_delay", busy, 0);
    step();
    chk("first_latch", busy, 1);

    // blink: visible BF frames, blank BF frames
    rst_n = 0; #1;
    blink = 1;
    @(negedge clk) rst_n = 1;
    for (int f = 0; f < 8; f++) begin
      wait_col(5'b11110, "blink_wait_col0");
`ifdef MAP_SCAN_BLINK_EN
      vis = ((f / BF) % 2) == 0;
`else
      vis = 1;
`endif
      chk($sformatf("blink_f%0d_row", f), row, vis ? 7'h01 : 7'h00);
      wait_fd("blink_wait_fd");
    end

    // randomized run against the model
    dec_mode = 0;
    rst_n = 0; model_reset(); #1;
    model_check();
    @(negedge clk) rst_n = 1;
    blink = 0;
    for (int i = 0; i < 3000; i++) begin
      en      = ($urandom_range(0, 9) != 0);
      load    = ($urandom_range(0, 7) == 0);
      sel     = SEL_W'($urandom);
      map_drv = {3'($urandom), 32'($urandom)};
      if ($urandom_range(0, 99) == 0) blink = ~blink;
      @(posedge clk);
      model_step(en, load, sel, map_in, blink);
      #1;
      model_check();
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 0; model_reset(); #1;
        model_check();
        @(negedge clk) rst_n = 1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
